reg_name_rx: RTL and testbench
==============================

// Module: reg_name_rx
// PURPOSE
//  Streaming ASCII register-name parser for the trace/debug console path.
//  Accepts one char/cycle over valid/ready, splits tokens on delimiters, maps each
//  token ("%rax".."%rh0") to its RegMap::reg_id_t, and emits one id per token.
//  Unknown or over-long tokens are flagged. Sits between the console byte source
//  and the debug register-access unit.
// PARAMETERS
//  MAX_LEN  8  max token length in chars; equals reg_name_t width / 8
// PORTS
//  clk        in   1   clock, all state on rising edge
//  reset      in   1   asynchronous, active-high reset
//  in_valid   in   1   in_char valid
//  in_ready   out  1   parser accepts in_char this cycle
//  in_char    in   8   ASCII input byte
//  out_valid  out  1   token result valid
//  out_ready  in   1   consumer accepts result
//  out_id     out  8   reg_id_t of token (rax=0 .. rh0=17)
//  out_err    out  1   token unknown or longer than MAX_LEN
// BEHAVIOUR
//  - Handshake: transfer occurs when valid && ready on the same rising edge.
//  - Delimiters: 0x20, 0x09, 0x2C, 0x0A, 0x0D, 0x00. All other bytes are token
//    chars. Matching is case-sensitive and exact.
//  - Token buffer: 64-bit reg_name_t, shift-insert: buf <= {buf[8:63], char}.
//    Result is right-justified and zero-padded, bit-identical to a string literal
//    assigned to reg_name_t. Cleared on entry to IDLE.
//  - Length counter: 0..MAX_LEN; overflow flag is sticky per token.
//  - FSM states:
//    - IDLE: in_ready=1. Delimiters are dropped. A token char is stored,
//      len=1, go to ACCUM.
//    - ACCUM: in_ready=1.
//      - Token char with len<MAX_LEN: store, len++.
//      - Token char with len==MAX_LEN: discard, set ovf, go to DRAIN.
//      - Delimiter: consumed, go to EMIT.
//    - DRAIN: in_ready=1. Token chars are discarded. A delimiter is consumed,
//      go to EMIT.
//    - EMIT: in_ready=0, out_valid=1. On out_ready go to IDLE; the first
//      in_ready=1 cycle follows.
//  - out_id/out_err are registered on the ACCUM/DRAIN->EMIT edge.
//    - Match among the 18 names: out_id=id, out_err=0.
//    - No match, or ovf set: out_id=0, out_err=1.
//  - Latency: delimiter accepted at edge N -> out_valid=1 after edge N.
//    Max rate is one token per len+2 cycles.
//  - Stall: while out_valid && !out_ready, out_id/out_err are held stable and
//    in_ready stays 0. No input is lost, because in_ready=0.
//  - Empty tokens (consecutive delimiters) produce no output.
//  - A token unterminated at end of stream stays in ACCUM indefinitely.
//  - Reset (any time, including mid-token or mid-EMIT):
//    - State IDLE, buf=0, len=0, ovf=0.
//    - out_valid=0, out_id=0, out_err=0.
//    - in_ready=0 while reset is asserted; partial token discarded.
// TESTING
//  1 "%rax " -> out_id=0, out_err=0, out_valid one cycle after the space
//  2 "%r15,%rflags\n" back-to-back -> ids 15 then 16, both err=0; in_ready low
//    exactly one cycle per EMIT
//  3 "%rh0 " with out_ready=0 for 3 cycles -> out_id=17 held 4 cycles,
//    in_ready=0 throughout, then IDLE
//  4 "%r16 " -> out_id=0, err=1; "%RAX " -> out_id=0, err=1
//  5 "%rflagsXY " (9 chars) then "%rsp " -> first err=1, id=0; second id=4, err=0
//  6 "%rb" then reset pulse, then "%rdi " -> single output id=7, err=0;
//    "  ,,\n" alone -> no output

Source files
------------

// File: rtl/reg_name_rx.sv
// Streaming ASCII register-name parser: one char per cycle in, one reg id per token out.
// Tokens are split on whitespace/comma/NUL and matched exactly against the 18 names.
module reg_name_rx #(
  parameter int unsigned MaxLen = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [7:0] in_char_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [7:0] out_id_o,
  output logic       out_err_o
);

  localparam int unsigned BufW   = 8 * MaxLen;
  localparam int unsigned LenW   = $clog2(MaxLen + 1);
  localparam int unsigned NNames = 18;

  // Right-justified, zero-padded names; index is the reg id.
  localparam logic [63:0] Names [NNames] = '{
    {32'h0, "%rax"}, {32'h0, "%rcx"}, {32'h0, "%rdx"}, {32'h0, "%rbx"},
    {32'h0, "%rsp"}, {32'h0, "%rbp"}, {32'h0, "%rsi"}, {32'h0, "%rdi"},
    {40'h0, "%r8"},  {40'h0, "%r9"},  {32'h0, "%r10"}, {32'h0, "%r11"},
    {32'h0, "%r12"}, {32'h0, "%r13"}, {32'h0, "%r14"}, {32'h0, "%r15"},
    {8'h0, "%rflags"}, {32'h0, "%rh0"}
  };

  typedef enum logic [1:0] {StIdle, StAccum, StDrain, StEmit} state_e;

  state_e            state_q, state_d;
  logic [BufW-1:0]   buf_q, buf_d;
  logic [LenW-1:0]   len_q, len_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        id_q, id_d;
  logic              err_q, err_d;
  logic              is_delim, hit, rdy;
  logic [7:0]        hit_id;

  always_comb begin
    is_delim = (in_char_i == 8'h20) || (in_char_i == 8'h09) || (in_char_i == 8'h2C) ||
               (in_char_i == 8'h0A) || (in_char_i == 8'h0D) || (in_char_i == 8'h00);
  end

  always_comb begin
    hit    = 1'b0;
    hit_id = 8'h00;
    for (int i = 0; i < NNames; i++) begin
      if (64'(buf_q) == Names[i]) begin
        hit    = 1'b1;
        hit_id = 8'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    len_d       = len_q;
    ovf_d       = ovf_q;
    id_d        = id_q;
    err_d       = err_q;
    rdy         = 1'b0;
    out_valid_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        rdy = 1'b1;
        if (in_valid_i && !is_delim) begin
          buf_d   = {{(BufW - 8){1'b0}}, in_char_i};
          len_d   = LenW'(1);
          state_d = StAccum;
        end
      end
      StAccum: begin
        rdy = 1'b1;
        if (in_valid_i) begin
          if (is_delim) begin
            id_d    = hit ? hit_id : 8'h00;
            err_d   = !hit || ovf_q;
            state_d = StEmit;
          end else if (len_q < LenW'(MaxLen)) begin
            buf_d = {buf_q[BufW-9:0], in_char_i};
            len_d = len_q + LenW'(1);
          end else begin
            ovf_d   = 1'b1;
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        rdy = 1'b1;
        if (in_valid_i && is_delim) begin
          id_d    = 8'h00;
          err_d   = 1'b1;
          state_d = StEmit;
        end
      end
      StEmit: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          buf_d   = '0;
          len_d   = '0;
          ovf_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Nothing may be accepted while reset is held.
    in_ready_o = rdy && !rst_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      buf_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      id_q    <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      id_q    <= id_d;
      err_q   <= err_d;
    end
  end

  assign out_id_o  = id_q;
  assign out_err_o = err_q;

endmodule

// File: tb/tb_reg_name_rx.sv
// Bench for reg_name_rx: directed token streams plus random streams, all checked
// against a token-level model (byte queues compared with the register name table).
module tb_reg_name_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_char = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_id;
  logic       out_err;

  int n_vec = 0;
  int n_bad = 0;

  string names [18] = '{"%rax", "%rcx", "%rdx", "%rbx", "%rsp", "%rbp", "%rsi", "%rdi",
                        "%r8", "%r9", "%r10", "%r11", "%r12", "%r13", "%r14", "%r15",
                        "%rflags", "%rh0"};

  byte unsigned tok[$];
  int           exp_id[$];
  int           exp_err[$];
  byte unsigned stream[$];

  always #5 clk = ~clk;

  reg_name_rx #(.MaxLen(8)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_char_i  (in_char),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_id_o   (out_id),
    .out_err_o  (out_err)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_delim(input byte unsigned c);
    return c == 8'h20 || c == 8'h09 || c == 8'h2C || c == 8'h0A || c == 8'h0D || c == 8'h00;
  endfunction

  // Token finished: look it up by name, anything over 8 chars is an error.
  function automatic void close_token();
    int id = -1;
    foreach (names[n]) begin
      if (tok.size() == names[n].len()) begin
        bit same = 1'b1;
        foreach (tok[k]) if (tok[k] != names[n][k]) same = 1'b0;
        if (same) id = n;
      end
    end
    if (tok.size() > 8 || id < 0) begin
      exp_id.push_back(0);
      exp_err.push_back(1);
    end else begin
      exp_id.push_back(id);
      exp_err.push_back(0);
    end
    tok.delete();
  endfunction

  task automatic step(input logic v, input logic [7:0] c, input logic r, output logic acc);
    logic out_fire;
    @(negedge clk);
    in_valid  = v;
    in_char   = c;
    out_ready = r;
    #1;
    check_eq("out_valid", int'(out_valid), int'(exp_id.size() != 0));
    check_eq("in_ready", int'(in_ready), int'(!out_valid));
    if (out_valid && exp_id.size() != 0) begin
      check_eq("out_id", int'(out_id), exp_id[0]);
      check_eq("out_err", int'(out_err), exp_err[0]);
    end
    acc      = v && in_ready;
    out_fire = out_valid && r;
    if (out_fire && exp_id.size() != 0) begin
      void'(exp_id.pop_front());
      void'(exp_err.pop_front());
    end
    if (acc) begin
      if (is_delim(c)) begin
        if (tok.size() != 0) close_token();
      end else begin
        tok.push_back(c);
      end
    end
  endtask

  task automatic send(input string s, input logic r);
    logic acc;
    for (int i = 0; i < s.len(); i++) begin
      int tries = 0;
      do begin
        step(1'b1, s[i], r, acc);
        tries++;
      end while (!acc && tries < 20);
      if (!acc) check_eq("accept_timeout", 0, 1);
    end
  endtask

  task automatic idle(input int n, input logic r);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, r, acc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_char  = "x";
    #1;
    check_eq("rst_in_ready", int'(in_ready), 0);
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_out_id", int'(out_id), 0);
    check_eq("rst_out_err", int'(out_err), 0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    tok.delete();
    exp_id.delete();
    exp_err.delete();
  endtask

  task automatic gen_token();
    int    kind = $urandom_range(0, 4);
    string nm   = names[$urandom_range(0, 17)];
    int    nd   = $urandom_range(1, 3);
    byte unsigned dl [6] = '{8'h20, 8'h09, 8'h2C, 8'h0A, 8'h0D, 8'h00};
    case (kind)
      0, 1: for (int k = 0; k < nm.len(); k++) stream.push_back(nm[k]);
      2: begin
        int p = $urandom_range(0, nm.len() - 1);
        for (int k = 0; k < nm.len(); k++)
          stream.push_back(k == p ? (nm[k] ^ 8'h20) : nm[k]);
      end
      3: begin
        for (int k = 0; k < nm.len(); k++) stream.push_back(nm[k]);
        repeat ($urandom_range(1, 4)) stream.push_back(8'($urandom_range(33, 126)));
      end
      default: repeat ($urandom_range(1, 11)) stream.push_back(8'($urandom_range(33, 126)));
    endcase
    repeat (nd) stream.push_back(dl[$urandom_range(0, 5)]);
  endtask

  initial begin
    logic acc;
    do_reset();
    idle(2, 1'b1);

    send("%rax ", 1'b1);
    idle(2, 1'b1);
    send("%r15,%rflags\n", 1'b1);
    idle(2, 1'b1);
    send("%rh0 ", 1'b0);
    idle(3, 1'b0);
    idle(2, 1'b1);
    send("%r16 %RAX ", 1'b1);
    idle(2, 1'b1);
    send("%rflagsXY %rsp ", 1'b1);
    idle(2, 1'b1);
    send("%rb", 1'b1);
    do_reset();
    send("%rdi ", 1'b1);
    idle(2, 1'b1);
    send("  ,,\n", 1'b1);
    idle(4, 1'b1);

    repeat (300) gen_token();
    while (stream.size() != 0) begin
      logic v = ($urandom_range(0, 3) != 0);
      step(v, stream[0], logic'($urandom_range(0, 2) != 0), acc);
      if (acc) void'(stream.pop_front());
    end
    idle(6, 1'b1);
    check_eq("drained", exp_id.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
